// File: rtl/inst_mem_responder.sv
// Instruction memory responder: word-addressed ROM/RAM with loader port and fixed-latency read pipe.
// Optional per-word even parity when INST_MEM_PARITY_EN is defined.
module inst_mem_responder #(
  parameter int          DEPTH_LOG2   = 10,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] NOP_WORD     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           pc,
  input  logic                  hold_i,
  output logic [31:0]           inst_o,
  output logic                  inst_valid_o,
  output logic                  addr_err_o,
  input  logic                  load_we_i,
  input  logic [DEPTH_LOG2-1:0] load_addr_i,
  input  logic [31:0]           load_data_i,
  input  logic                  load_par_inv_i,
  output logic                  load_busy_o,
  output logic                  parity_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("READ_LATENCY must be 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    RESUME = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        perr;
    logic [31:0] data;
  } stage_t;

  localparam stage_t BUBBLE = '{1'b0, 1'b0, 1'b0, NOP_WORD};

  state_t state_q, state_d;
  stage_t pipe_q [READ_LATENCY];
  stage_t pipe_d [READ_LATENCY];
  stage_t rd;

  logic [31:0] mem_q [DEPTH];
`ifdef INST_MEM_PARITY_EN
  logic par_q [DEPTH];
`endif

  logic [DEPTH_LOG2-1:0] idx;
  logic                  misal;
  logic                  accept;

  assign idx    = pc[DEPTH_LOG2+1:2];
  assign misal  = pc[1:0] != 2'b00;
  assign accept = (state_q == RUN) && ce && !hold_i && !load_we_i;

  // Upper pc bits alias by design; parity inject is idle without parity.
  logic unused_bits;
`ifdef INST_MEM_PARITY_EN
  assign unused_bits = ^pc[31:DEPTH_LOG2+2];
`else
  assign unused_bits = ^{pc[31:DEPTH_LOG2+2], load_par_inv_i};
`endif

  // Loader FSM next state: any write parks the fetch side for two cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (load_we_i) state_d = LOAD;
      LOAD:    if (!load_we_i) state_d = RESUME;
      RESUME:  state_d = load_we_i ? LOAD : RUN;
      default: state_d = RUN;
    endcase
  end

  // Read port: build the stage-0 entry for this cycle.
  always_comb begin
    rd = BUBBLE;
    if (accept) begin
      rd.valid = 1'b1;
      if (misal) begin
        rd.err = 1'b1;
      end else begin
        rd.data = mem_q[idx];
`ifdef INST_MEM_PARITY_EN
        rd.perr = (^mem_q[idx]) ^ par_q[idx];
`endif
      end
    end
  end

  // Pipe advance: shift only when not held.
  always_comb begin
    for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i];
    if (!hold_i) begin
      pipe_d[0] = rd;
      for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // State and pipe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= BUBBLE;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Loader writes land regardless of state or hold.
  always_ff @(posedge clk) begin
    if (!rst && load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
`ifdef INST_MEM_PARITY_EN
      par_q[load_addr_i] <= (^load_data_i) ^ load_par_inv_i;
`endif
    end
  end

  assign inst_o       = pipe_q[READ_LATENCY-1].data;
  assign inst_valid_o = pipe_q[READ_LATENCY-1].valid;
  assign addr_err_o   = pipe_q[READ_LATENCY-1].err;
  assign parity_err_o = pipe_q[READ_LATENCY-1].perr;
  assign load_busy_o  = state_q != RUN;

endmodule
